// File: rtl/line_cache_3x3.sv
// line_cache_3x3
// Line cache between the GBA capture stage and the HDMI image generator.
// Captured lines go into a 4-slot ring of 240-pixel RGB888 buffers and a
// 3x3 neighbourhood around curPxl is presented with two cycles of latency.
// The window (rdPtr-1, rdPtr, rdPtr+1) is protected: a line may only be
// accepted while fewer than three slots hold unreleased lines.
// Optional build macro LINE_CACHE_DBG_EN adds the dropCnt output
// (saturating count of dropped lines, cleared by reset or a new frame).

module line_cache_3x3 #(
    parameter int LINE_PIXELS = 240,
    parameter int FRAME_LINES = 160,
    parameter int SLOTS       = 4
) (
    input  logic        pxlClk,
    input  logic        rstN,
    input  logic        wrValid,
    input  logic [7:0]  wrIdx,
    input  logic [23:0] wrRGB,
    input  logic        wrLineDone,
    input  logic        newFrameIn,
    input  logic        nextLine,
    input  logic        cacheUpdate,
    input  logic [7:0]  curPxl,
    output logic [71:0] prevLineOut,
    output logic [71:0] curLineOut,
    output logic [71:0] nextLineOut,
    output logic        sameLine,
    output logic        overflow
`ifdef LINE_CACHE_DBG_EN
    ,
    output logic [7:0]  dropCnt
`endif
);

    localparam logic [7:0] LAST_PX   = 8'(LINE_PIXELS - 1);
    localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [23:0] mem [SLOTS][LINE_PIXELS];
    logic        nf_q, nf_rise;
    logic [1:0]  wr_ptr, rd_ptr, rd_nxt, rd_prv;
    logic [3:0]  valid, valid_nxt;
    logic [2:0]  valid_cnt;
    logic [7:0]  rd_line_idx;
    logic        adv_pending, same_line_q, overflow_q;
    logic        slot_free, line_accept, line_drop, adv_set, commit;
    logic [7:0]  col_c, col_l, col_r;
    logic [1:0]  slot_p, slot_n;
    logic [7:0]  s1_col_l, s1_col_c, s1_col_r;
    logic [1:0]  s1_slot_p, s1_slot_c, s1_slot_n;
    logic [71:0] prev_q, cur_q, next_q;

    // Decode the control events of this cycle; a new-frame edge overrides everything else.
    always_comb begin
        nf_rise     = newFrameIn & ~nf_q;
        rd_nxt      = rd_ptr + 2'd1;
        rd_prv      = rd_ptr - 2'd1;
        valid_cnt   = 3'(valid[0]) + 3'(valid[1]) + 3'(valid[2]) + 3'(valid[3]);
        slot_free   = valid_cnt < 3'd3;
        line_accept = wrLineDone & slot_free & ~nf_rise;
        line_drop   = wrLineDone & ~slot_free & ~nf_rise;
        adv_set     = nextLine & ~same_line_q & ~nf_rise;
        commit      = cacheUpdate & (adv_pending | adv_set) & ~nf_rise;
        valid_nxt   = valid;
        if (commit) valid_nxt[rd_ptr] = 1'b0;
        if (line_accept) valid_nxt[wr_ptr] = 1'b1;
    end

    // Next-state logic: wait for the first line, then run until the next frame starts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (line_accept || valid != 4'd0) state_nxt = FILL;
            FILL:    if (valid[rd_ptr]) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (nf_rise) state_nxt = FLUSH;
    end

    // State register.
    always_ff @(posedge pxlClk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ring pointers, valid flags, read window advance and the sameLine flag.
    always_ff @(posedge pxlClk or negedge rstN) begin
        if (!rstN) begin
            nf_q        <= 1'b0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            valid       <= 4'd0;
            rd_line_idx <= 8'd0;
            adv_pending <= 1'b0;
            same_line_q <= 1'b1;
        end else begin
            nf_q <= newFrameIn;
            if (nf_rise) begin
                wr_ptr      <= 2'd0;
                rd_ptr      <= 2'd0;
                valid       <= 4'd0;
                rd_line_idx <= 8'd0;
                adv_pending <= 1'b0;
                same_line_q <= 1'b1;
            end else begin
                valid       <= valid_nxt;
                same_line_q <= ~valid[rd_nxt];
                if (line_accept) wr_ptr <= wr_ptr + 2'd1;
                if (commit) begin
                    rd_ptr      <= rd_nxt;
                    adv_pending <= 1'b0;
                    if (rd_line_idx != LAST_LINE) rd_line_idx <= rd_line_idx + 8'd1;
                end else if (adv_set) begin
                    adv_pending <= 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a completed line had nowhere to go. Survives a new frame.
    always_ff @(posedge pxlClk or negedge rstN) begin
        if (!rstN)          overflow_q <= 1'b0;
        else if (line_drop) overflow_q <= 1'b1;
    end

    // Capture pixels; writes are blocked while the ring is full so the window stays intact.
    always_ff @(posedge pxlClk) begin
        if (wrValid && wrIdx <= LAST_PX && slot_free) mem[wr_ptr][wrIdx] <= wrRGB;
    end

    // Horizontal and vertical clamping of the neighbourhood addresses.
    always_comb begin
        col_c  = (curPxl > LAST_PX) ? LAST_PX : curPxl;
        col_l  = (col_c == 8'd0) ? col_c : col_c - 8'd1;
        col_r  = (col_c == LAST_PX) ? col_c : col_c + 8'd1;
        slot_p = (rd_line_idx == 8'd0) ? rd_ptr : rd_prv;
        slot_n = (valid[rd_nxt] && rd_line_idx != LAST_LINE) ? rd_nxt : rd_ptr;
    end

    // Stage 1 registers the resolved addresses, stage 2 reads all nine pixels together.
    always_ff @(posedge pxlClk or negedge rstN) begin
        if (!rstN) begin
            s1_col_l  <= 8'd0;
            s1_col_c  <= 8'd0;
            s1_col_r  <= 8'd0;
            s1_slot_p <= 2'd0;
            s1_slot_c <= 2'd0;
            s1_slot_n <= 2'd0;
            prev_q    <= 72'd0;
            cur_q     <= 72'd0;
            next_q    <= 72'd0;
        end else begin
            s1_col_l  <= col_l;
            s1_col_c  <= col_c;
            s1_col_r  <= col_r;
            s1_slot_p <= slot_p;
            s1_slot_c <= rd_ptr;
            s1_slot_n <= slot_n;
            prev_q    <= {mem[s1_slot_p][s1_col_l], mem[s1_slot_p][s1_col_c], mem[s1_slot_p][s1_col_r]};
            cur_q     <= {mem[s1_slot_c][s1_col_l], mem[s1_slot_c][s1_col_c], mem[s1_slot_c][s1_col_r]};
            next_q    <= {mem[s1_slot_n][s1_col_l], mem[s1_slot_n][s1_col_c], mem[s1_slot_n][s1_col_r]};
        end
    end

    assign prevLineOut = (state == RUN) ? prev_q : 72'd0;
    assign curLineOut  = (state == RUN) ? cur_q  : 72'd0;
    assign nextLineOut = (state == RUN) ? next_q : 72'd0;
    assign sameLine    = same_line_q;
    assign overflow    = overflow_q;

`ifdef LINE_CACHE_DBG_EN
    logic [7:0] drop_cnt_q;

    // Saturating dropped-line counter, restarted with each frame.
    always_ff @(posedge pxlClk or negedge rstN) begin
        if (!rstN)                                 drop_cnt_q <= 8'd0;
        else if (nf_rise)                          drop_cnt_q <= 8'd0;
        else if (line_drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end

    assign dropCnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_line_cache_3x3.sv
// tb_line_cache_3x3
// Scoreboarded bench for line_cache_3x3. The reference model keeps the
// accepted lines of the frame as plain arrays plus the index of the current
// line, and derives the 3x3 neighbourhood directly from those.

module tb_line_cache_3x3;

    logic        pxlClk = 1'b0;
    logic        rstN;
    logic        wrValid, wrLineDone, newFrameIn, nextLine, cacheUpdate;
    logic [7:0]  wrIdx, curPxl;
    logic [23:0] wrRGB;
    logic [71:0] prevLineOut, curLineOut, nextLineOut;
    logic        sameLine, overflow;
`ifdef LINE_CACHE_DBG_EN
    logic [7:0]  dropCnt;
`endif

    line_cache_3x3 dut (
        .pxlClk      (pxlClk),
        .rstN        (rstN),
        .wrValid     (wrValid),
        .wrIdx       (wrIdx),
        .wrRGB       (wrRGB),
        .wrLineDone  (wrLineDone),
        .newFrameIn  (newFrameIn),
        .nextLine    (nextLine),
        .cacheUpdate (cacheUpdate),
        .curPxl      (curPxl),
        .prevLineOut (prevLineOut),
        .curLineOut  (curLineOut),
        .nextLineOut (nextLineOut),
        .sameLine    (sameLine),
        .overflow    (overflow)
`ifdef LINE_CACHE_DBG_EN
        ,
        .dropCnt     (dropCnt)
`endif
    );

    always #5 pxlClk = ~pxlClk;

    typedef struct {
        logic [71:0] p;
        logic [71:0] c;
        logic [71:0] n;
        logic        same;
        logic        ovf;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] mlines [32][240];
    logic [23:0] pend_line [240];
    int          mcount = 0;
    int          mrd = 0;
    bit          mpend = 0;
    bit          movf = 0;
    int          mdrop = 0;
    bit          rd_req = 0;
    bit          d1 = 0;
    bit          d2 = 0;

    // Neighbourhood row of one model line around a (clamped) pixel index.
    function automatic logic [71:0] row_pix(int line, int px);
        int c, l, r;
        c = (px > 239) ? 239 : px;
        l = (c == 0) ? 0 : c - 1;
        r = (c == 239) ? 239 : c + 1;
        return {mlines[line][l], mlines[line][c], mlines[line][r]};
    endfunction

    function automatic bit m_same();
        return !(mrd + 1 < mcount);
    endfunction

    task automatic tick();
        @(posedge pxlClk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [71:0] act, logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issue one read request and queue what the model says it must return.
    task automatic applyStimulus(int px, string tag);
        exp_t e;
        if (mcount == 0) begin
            e.p = 72'd0;
            e.c = 72'd0;
            e.n = 72'd0;
        end else begin
            e.c = row_pix(mrd, px);
            e.p = row_pix((mrd == 0) ? mrd : mrd - 1, px);
            e.n = row_pix((mrd + 1 < mcount) ? mrd + 1 : mrd, px);
        end
        e.same = m_same();
        e.ovf  = movf;
        e.tag  = tag;
        sbq.push_back(e);
        curPxl = 8'(px);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_burst(int n, string tag);
        for (int k = 0; k < n; k++) applyStimulus($urandom_range(0, 255), tag);
        repeat (3) tick();
    endtask

    // Capture one full line (with random gaps and one out-of-range write).
    task automatic write_line(bit patterned, int tag);
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                wrValid = 1'b0;
                tick();
            end
            pend_line[i] = patterned ? {8'(i), 8'(tag), 8'h55} : 24'($urandom);
            wrValid = 1'b1;
            wrIdx   = 8'(i);
            wrRGB   = pend_line[i];
            tick();
        end
        wrIdx = 8'($urandom_range(240, 255));
        wrRGB = 24'($urandom);
        tick();
        wrValid    = 1'b0;
        wrLineDone = 1'b1;
        tick();
        wrLineDone = 1'b0;
        if (mcount - mrd < 3) begin
            for (int i = 0; i < 240; i++) mlines[mcount][i] = pend_line[i];
            mcount++;
        end else begin
            movf = 1'b1;
            if (mdrop < 255) mdrop++;
        end
        repeat (3) tick();
    endtask

    // mode 0: nextLine, then cacheUpdate later; mode 1: both in the same cycle.
    task automatic advance(int mode);
        if (mode == 0) begin
            nextLine = 1'b1;
            tick();
            nextLine = 1'b0;
            if (!m_same()) mpend = 1'b1;
            repeat (2) tick();
            cacheUpdate = 1'b1;
            tick();
            cacheUpdate = 1'b0;
            if (mpend) begin
                mrd++;
                mpend = 1'b0;
            end
        end else begin
            nextLine    = 1'b1;
            cacheUpdate = 1'b1;
            tick();
            nextLine    = 1'b0;
            cacheUpdate = 1'b0;
            if (!m_same()) mrd++;
        end
        repeat (3) tick();
    endtask

    task automatic new_frame();
        newFrameIn = 1'b1;
        tick();
        checkOutput("flush.same", 72'(sameLine), 72'(1'b1));
        checkOutput("flush.prev", prevLineOut, 72'd0);
        checkOutput("flush.cur", curLineOut, 72'd0);
        checkOutput("flush.ovf", 72'(overflow), 72'(movf));
        newFrameIn = 1'b0;
        mcount = 0;
        mrd    = 0;
        mpend  = 1'b0;
        mdrop  = 0;
        repeat (3) tick();
    endtask

    // Monitor: a request sampled two negedges ago has its result on the outputs now.
    always @(negedge pxlClk) begin
        exp_t e;
        if (d2) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard: got a result, want a queued expectation");
            end else begin
                e = sbq.pop_front();
                checkOutput({e.tag, ".prev"}, prevLineOut, e.p);
                checkOutput({e.tag, ".cur"}, curLineOut, e.c);
                checkOutput({e.tag, ".next"}, nextLineOut, e.n);
                checkOutput({e.tag, ".same"}, 72'(sameLine), 72'(e.same));
                checkOutput({e.tag, ".ovf"}, 72'(overflow), 72'(e.ovf));
            end
        end
        d2 = d1;
        d1 = rd_req;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        int op;
        rstN = 1'b0;
        wrValid = 1'b0;
        wrIdx = 8'd0;
        wrRGB = 24'd0;
        wrLineDone = 1'b0;
        newFrameIn = 1'b0;
        nextLine = 1'b0;
        cacheUpdate = 1'b0;
        curPxl = 8'd0;
        repeat (3) tick();
        checkOutput("reset.prev", prevLineOut, 72'd0);
        checkOutput("reset.cur", curLineOut, 72'd0);
        checkOutput("reset.next", nextLineOut, 72'd0);
        checkOutput("reset.same", 72'(sameLine), 72'(1'b1));
        checkOutput("reset.ovf", 72'(overflow), 72'(1'b0));
        rstN = 1'b1;
        tick();
        read_burst(3, "idle");

        write_line(1'b1, 0);
        write_line(1'b1, 1);
        applyStimulus(5, "px5");
        applyStimulus(0, "px0");
        applyStimulus(239, "px239");
        applyStimulus(250, "px250");
        read_burst(6, "line0");

        advance(0);
        applyStimulus(0, "adv1_px0");
        read_burst(6, "adv1");
        write_line(1'b0, 2);
        read_burst(6, "line2");

        write_line(1'b0, 3);
        write_line(1'b0, 4);
        applyStimulus(239, "ovf_px239");
        read_burst(6, "ovf");

        advance(1);
        read_burst(4, "adv2");
        advance(0);
        read_burst(4, "adv3");
        advance(0);
        read_burst(4, "noadv");

        new_frame();
        write_line(1'b1, 0);
        applyStimulus(0, "f2_px0");
        applyStimulus(239, "f2_px239");
        read_burst(6, "frame2");

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                if (mcount < 30) write_line(1'b0, it);
                else new_frame();
            end else if (op <= 6) begin
                advance($urandom_range(0, 1));
            end else if (op == 7 && (it % 10) == 7) begin
                new_frame();
            end
            read_burst(2, "rnd");
        end

        guard = 0;
        while ((sbq.size() != 0 || d1 || d2) && guard < 20) begin
            tick();
            guard++;
        end
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending results, want 0", sbq.size());
        end
`ifdef LINE_CACHE_DBG_EN
        checkOutput("dropCnt", 72'(dropCnt), 72'(mdrop));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
